// File: rtl/led_anim_engine.sv
// led_anim_engine: LED bar animator (rotate/bounce/bar/count); define LED_ANIM_STEP_EN to add the i_step single-frame input
module led_anim_engine #(
  parameter int LED_W    = 16,
  parameter int BASE_DIV = 25000000,
  parameter int DIV_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_dir,
  input  logic [1:0]       i_speed,
`ifdef LED_ANIM_STEP_EN
  input  logic             i_step,
`endif
  output logic [LED_W-1:0] o_led,
  output logic             o_frame_tick
);
  typedef enum logic [1:0] {ROTATE, BOUNCE, BAR, COUNT} mode_t;
  localparam int PW = $clog2(LED_W);
  localparam int BW = $clog2(LED_W + 1);
  mode_t            r_mode_q;
  logic [DIV_W-1:0] r_pdiv;
  logic [LED_W-1:0] r_rot;
  logic [LED_W-1:0] r_cnt;
  logic [PW-1:0]    r_pos;
  logic             r_up;
  logic [BW-1:0]    r_bar;
  logic             r_tick_q;
  logic [DIV_W-1:0] w_period;
  logic             w_mode_chg;
  logic             w_step;
  logic             w_tick;
  logic [LED_W-1:0] w_bar;
  logic [LED_W-1:0] w_led;
`ifdef LED_ANIM_STEP_EN
  logic             r_step_q;
  assign w_step = !i_en && i_step && !r_step_q;
  always_ff @(posedge i_clk) r_step_q <= i_rst && i_step;
`else
  assign w_step = 1'b0;
`endif
  assign w_period   = DIV_W'(BASE_DIV) << i_speed;
  assign w_mode_chg = i_mode != r_mode_q;
  assign w_tick     = !w_mode_chg && ((i_en && r_pdiv >= w_period - DIV_W'(1)) || w_step);
  always_comb begin
    w_bar = '0;
    for (int i = 0; i < LED_W; i++)
      w_bar[i] = i_dir ? (i >= LED_W - int'(r_bar)) : (i < int'(r_bar));
  end
  assign w_led = r_mode_q == ROTATE ? r_rot :
                 r_mode_q == BOUNCE ? LED_W'(1) << r_pos :
                 r_mode_q == BAR    ? w_bar : r_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_mode_q     <= ROTATE;
      r_pdiv       <= '0;
      r_rot        <= LED_W'(1);
      r_pos        <= '0;
      r_up         <= 1'b1;
      r_bar        <= '0;
      r_cnt        <= '0;
      r_tick_q     <= 1'b0;
      o_led        <= '0;
      o_frame_tick <= 1'b0;
    end else begin
      o_led        <= w_led;
      r_tick_q     <= w_tick;
      o_frame_tick <= r_tick_q;
      if (w_mode_chg) begin
        r_mode_q <= mode_t'(i_mode);
        r_pdiv   <= '0;
        r_rot    <= LED_W'(1);
        r_pos    <= '0;
        r_up     <= 1'b1;
        r_bar    <= '0;
        r_cnt    <= '0;
      end else begin
        if (i_en) r_pdiv <= w_tick ? '0 : r_pdiv + DIV_W'(1);
        if (w_tick) begin
          case (r_mode_q)
            ROTATE: r_rot <= i_dir ? {r_rot[0], r_rot[LED_W-1:1]} : {r_rot[LED_W-2:0], r_rot[LED_W-1]};
            BOUNCE: begin
              r_pos <= r_up ? r_pos + PW'(1) : r_pos - PW'(1);
              r_up  <= r_up ? (r_pos != PW'(LED_W - 2)) : (r_pos == PW'(1));
            end
            BAR:    r_bar <= r_bar == BW'(LED_W) ? '0 : r_bar + BW'(1);
            COUNT:  r_cnt <= i_dir ? r_cnt - LED_W'(1) : r_cnt + LED_W'(1);
          endcase
        end
      end
    end
  end
endmodule

// File: doc/led_anim_engine.md
Name: led_anim_engine

Overview:
- Parametrised successor to the two-switch LED animation block. Drives an LED_W-wide LED bar with four selectable patterns: rotate, bounce, bar fill and binary count.
- A programmable prescaler sets the frame rate. Direction, pause and live mode switching are supported.
- Sits between the board switch/button synchronisers and the LED pins of the display module.

Parameters:
- LED_W, 16, number of LEDs (4..32).
- BASE_DIV, 25000000, clock cycles per frame at speed=0 (>=1).
- DIV_W, 32, prescaler counter width; must hold BASE_DIV<<3.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (0 = reset, sampled on the clk rising edge)
- en  in  1  1 = animate, 0 = freeze (prescaler and frame hold)
- mode  in  2  0 ROTATE, 1 BOUNCE, 2 BAR, 3 COUNT
- dir  in  1  0 = up/left, 1 = down/right (ignored in BOUNCE)
- speed  in  2  frame period P = BASE_DIV << speed cycles
- led  out  LED_W  registered LED pattern
- frame_tick  out  1  one-cycle pulse on each frame advance

Behaviour:
- Reset (rst=0 at an edge):
  - led=0, frame_tick=0, prescaler=0, mode_q=0.
  - rot=1, pos=0, up=1, bar=0, cnt=0.
- Pipeline: inputs sample state; led = f(state) registered, so led lags state by 1 cycle. The first cycle after reset release shows the initial frame of the current mode.
- Prescaler:
  - When en=1: increments each cycle. tick = en && (pdiv >= P-1); on tick, pdiv returns to 0.
  - Using >= gives an immediate tick if speed is lowered mid-period.
  - When en=0: pdiv and frame state hold, no tick.
- frame_tick is registered and asserts the cycle after the tick, aligned with the led update.
- Frame state advances only on tick:
  - ROTATE:
    - led=rot.
    - dir=0: rotate left, bit LED_W-1 wraps to bit0.
    - dir=1: rotate right, bit0 wraps to bit LED_W-1.
  - BOUNCE:
    - led=1<<pos.
    - up=1: pos+1; on reaching LED_W-1, up clears.
    - up=0: pos-1; on reaching 0, up sets.
    - No dwell at the ends; sequence is 0,1,..,N-1,N-2,..,0,1.
  - BAR:
    - bar counts 0..LED_W, then wraps to 0 on the next tick.
    - dir=0: led = low 'bar' bits set.
    - dir=1: led = high 'bar' bits set.
    - bar=LED_W gives all ones.
  - COUNT:
    - led=cnt (LED_W bits).
    - dir=0: +1; dir=1: -1; modulo 2^LED_W.
- Mode change (mode != mode_q):
  - Next edge: mode_q<=mode, pdiv<=0, state reinitialised to the initial frame (rot=1, pos=0, up=1, bar=0, cnt=0), no tick that cycle.
  - led shows the initial frame one cycle later. Applies even when en=0.
- Changing dir mid-pattern takes effect on the next tick without reinitialising.
- Reset mid-animation: fully reinitialises on that edge, regardless of en or mode.

Optional Feature:
- Macro: LED_ANIM_STEP_EN.
- Defined: adds input port step (1 bit, synchronised, level). While en=0, a 0->1 edge on step (detected via a registered copy) forces one tick: frame advances once and frame_tick pulses. step is ignored while en=1.
- Undefined: no step port; en=0 is a pure freeze.

Test Plan (LED_W=8, BASE_DIV=2):
- Reset then ROTATE, en=1, dir=0, speed=0 -> led 0x00 in reset, 0x01 next cycle; then 0x02,0x04,...,0x80,0x01, changing every 2 cycles; frame_tick pulses aligned with each change.
- BOUNCE, speed=0 -> led sequence 0x01,0x02,...,0x80,0x40,...,0x01,0x02; no repeated 0x80 or 0x01 at the turns.
- BAR dir=1 -> 0x00,0x80,0xC0,...,0xFF,0x00. Then COUNT dir=1 from reset -> 0x00,0xFF,0xFE.
- speed=3, en=1 -> 16 cycles per frame. Set en=0 for 40 cycles -> led and frame_tick frozen; resume -> next change exactly after the remaining prescaler count.
- Switch mode ROTATE->COUNT mid-period at led=0x08 -> led=0x00 two edges later; next increment P cycles after the reinit.
- With LED_ANIM_STEP_EN, en=0, three step pulses -> ROTATE advances 0x01->0x02->0x04->0x08, one frame_tick each; step held high gives no extra advance.
